// File: rtl/reg_scoreboard_if.sv
// Decode/writeback bundle for the register-hazard scoreboard.
//   master : decode stage and writeback. It drives the instruction fields,
//            the flush and the long-op completion, and it sees the
//            issue/stall decision.
//   slave  : the scoreboard itself.
// Signals:
//   id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_rd_wr, id_lat
//            : the instruction held in decode.
//   ex_flush : squashes the decode instruction in this cycle.
//   wb_done, wb_rd : a long op completes, and the register it writes.
//   stall, issue, busy_vec, long_full : the scoreboard's decision and its state.
interface reg_scoreboard_if #(
  parameter int NREGS = 32
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [4:0]       id_rd;
  logic             id_rd_wr;
  logic [1:0]       id_lat;
  logic             ex_flush;
  logic             wb_done;
  logic [4:0]       wb_rd;
  logic             stall;
  logic             issue;
  logic [NREGS-1:0] busy_vec;
  logic             long_full;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_rd_wr, id_lat, ex_flush, wb_done, wb_rd,
    input  stall, issue, busy_vec, long_full
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_rd_wr, id_lat, ex_flush, wb_done, wb_rd,
    output stall, issue, busy_vec, long_full
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard and issue controller for the decode stage.
// It tracks destinations that have pending multi-cycle writes. Loads use a
// fixed countdown. Long ops (mul/div) stay busy until writeback reports that
// they are done. Each cycle the block decides whether the decode instruction
// issues or stalls. A stall holds PC and IF/ID and inserts a bubble into EX.
// Ports:
//   clk   : rising-edge clock.
//   rst_n : synchronous, active-low reset.
//   sb    : reg_scoreboard_if.slave. It carries the decode fields, the flush,
//           the writeback completion, and the stall/issue/busy_vec/long_full
//           outputs.
module reg_scoreboard #(
  parameter int NREGS    = 32,
  parameter int LOAD_LAT = 1,
  parameter int MAX_LONG = 2
) (
  input logic             clk,
  input logic             rst_n,
  reg_scoreboard_if.slave sb
);
  localparam int LW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  localparam int CW = (MAX_LONG < 1) ? 1 : $clog2(MAX_LONG + 1);

  localparam logic [1:0] LAT_LOAD = 2'd1;
  localparam logic [1:0] LAT_LONG = 2'd2;

  logic [LW-1:0]    ld_cnt [NREGS];
  logic [NREGS-1:0] lg;
  logic [CW-1:0]    long_cnt;

  logic [NREGS-1:0] busy;
  logic             long_full;
  logic             raw_a, raw_b, waw, struct_haz;
  logic             go, stall, issue;
  logic             issue_ld, issue_lg, wb_hit;

  // Busy view of the registered state only. A wb_done in this cycle is not
  // bypassed, so a reader of that register stalls one more cycle.
  always_comb begin
    // NOTE: give every always_comb output a default before any conditional
    // logic. A path that leaves an output unassigned infers a latch.
    busy = '0;
    for (int r = 0; r < NREGS; r++) begin
      busy[r] = (ld_cnt[r] != '0) | lg[r];
    end
    busy[0] = 1'b0;
  end

  assign long_full  = (long_cnt == CW'(MAX_LONG));

  assign raw_a      = sb.id_rs_used & (sb.id_rs != 5'd0) & busy[sb.id_rs];
  assign raw_b      = sb.id_rt_used & (sb.id_rt != 5'd0) & busy[sb.id_rt];
  assign waw        = sb.id_rd_wr   & (sb.id_rd != 5'd0) & busy[sb.id_rd];
  assign struct_haz = (sb.id_lat == LAT_LONG) & long_full;

  // A flush overrides everything: the squashed instruction neither stalls
  // nor issues, so it leaves no state behind.
  assign go    = sb.id_valid & ~sb.ex_flush;
  assign stall = go & (raw_a | raw_b | waw | struct_haz);
  assign issue = go & ~stall;

  // Writes to r0 are never tracked. That applies to loads and long ops alike.
  assign issue_ld = issue & sb.id_rd_wr & (sb.id_rd != 5'd0) & (sb.id_lat == LAT_LOAD);
  assign issue_lg = issue & sb.id_rd_wr & (sb.id_rd != 5'd0) & (sb.id_lat == LAT_LONG);

  // A completion counts only when it names a register that is still pending.
  // Any other completion is ignored and does not touch long_cnt.
  assign wb_hit = sb.wb_done & lg[sb.wb_rd];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: this countdown array is ordinary flops, not a RAM. It must be
      // cleared because busy decodes it directly.
      for (int r = 0; r < NREGS; r++) begin
        ld_cnt[r] <= '0;
      end
      lg       <= '0;
      long_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register here samples values from before this edge.
      for (int r = 1; r < NREGS; r++) begin
        if (issue_ld && (sb.id_rd == 5'(r))) begin
          ld_cnt[r] <= LW'(LOAD_LAT);
        end else if (ld_cnt[r] != '0) begin
          ld_cnt[r] <= ld_cnt[r] - 1'b1;
        end

        // A set and a clear cannot meet here. A pending register blocks a
        // new long issue to it through the WAW stall, and a clear needs
        // lg[r] already set.
        if (issue_lg && (sb.id_rd == 5'(r))) begin
          lg[r] <= 1'b1;
        end else if (wb_hit && (sb.wb_rd == 5'(r))) begin
          lg[r] <= 1'b0;
        end
      end
      ld_cnt[0] <= '0;
      lg[0]     <= 1'b0;

      // A long issue and a completion in the same cycle cancel out.
      // Saturation guards keep the counter from wrapping.
      case ({issue_lg, wb_hit})
        2'b10: if (!long_full)         long_cnt <= long_cnt + 1'b1;
        2'b01: if (long_cnt != '0)     long_cnt <= long_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign sb.busy_vec  = busy;
  assign sb.long_full = long_full;
  assign sb.stall     = stall;
  assign sb.issue     = issue;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard. The driver applies one decode/
// writeback vector per cycle. It pushes the hand-computed response into
// exp_q. The monitor pops an entry on each falling edge and compares it with
// the outputs. A second instance with LOAD_LAT=3 sees the same inputs and is
// compared only where its entries carry c3.
module tb_reg_scoreboard;
  logic clk;
  logic rst_n;

  reg_scoreboard_if #(.NREGS(32)) bus ();
  reg_scoreboard_if #(.NREGS(32)) bus3 ();

  reg_scoreboard #(.NREGS(32), .LOAD_LAT(1), .MAX_LONG(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus)
  );

  reg_scoreboard #(.NREGS(32), .LOAD_LAT(3), .MAX_LONG(2)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (bus3)
  );

  assign bus3.id_valid   = bus.id_valid;
  assign bus3.id_rs      = bus.id_rs;
  assign bus3.id_rt      = bus.id_rt;
  assign bus3.id_rs_used = bus.id_rs_used;
  assign bus3.id_rt_used = bus.id_rt_used;
  assign bus3.id_rd      = bus.id_rd;
  assign bus3.id_rd_wr   = bus.id_rd_wr;
  assign bus3.id_lat     = bus.id_lat;
  assign bus3.ex_flush   = bus.ex_flush;
  assign bus3.wb_done    = bus.wb_done;
  assign bus3.wb_rd      = bus.wb_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        stall;
    logic        issue;
    logic [31:0] busy;
    logic        full;
    bit          c3;
    logic        stall3;
    logic        issue3;
    logic [31:0] busy3;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // Monitor: outputs are combinational and present every cycle. It samples
  // mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.tag, ".stall"}, 32'(bus.stall),     32'(e.stall));
      check({e.tag, ".issue"}, 32'(bus.issue),     32'(e.issue));
      check({e.tag, ".busy"},  bus.busy_vec,       e.busy);
      check({e.tag, ".full"},  32'(bus.long_full), 32'(e.full));
      if (e.c3) begin
        check({e.tag, ".stall3"}, 32'(bus3.stall), 32'(e.stall3));
        check({e.tag, ".issue3"}, 32'(bus3.issue), 32'(e.issue3));
        check({e.tag, ".busy3"},  bus3.busy_vec,   e.busy3);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rs, input logic rsu,
                     input logic [4:0] rt, input logic rtu,
                     input logic [4:0] rd, input logic rdw, input logic [1:0] lat,
                     input logic fl, input logic wbd, input logic [4:0] wbr);
    bus.id_valid   = v;
    bus.id_rs      = rs;
    bus.id_rs_used = rsu;
    bus.id_rt      = rt;
    bus.id_rt_used = rtu;
    bus.id_rd      = rd;
    bus.id_rd_wr   = rdw;
    bus.id_lat     = lat;
    bus.ex_flush   = fl;
    bus.wb_done    = wbd;
    bus.wb_rd      = wbr;
  endtask

  task automatic expect1(input string tag, input logic st, input logic is,
                         input logic [31:0] bz, input logic fu);
    exp_t e;
    e.tag = tag; e.stall = st; e.issue = is; e.busy = bz; e.full = fu;
    e.c3 = 1'b0; e.stall3 = 1'b0; e.issue3 = 1'b0; e.busy3 = '0;
    exp_q.push_back(e);
  endtask

  task automatic expect3(input string tag, input logic st, input logic is,
                         input logic [31:0] bz, input logic fu,
                         input logic st3, input logic is3, input logic [31:0] bz3);
    exp_t e;
    e.tag = tag; e.stall = st; e.issue = is; e.busy = bz; e.full = fu;
    e.c3 = 1'b1; e.stall3 = st3; e.issue3 = is3; e.busy3 = bz3;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset held, with a valid decode and wb_done active.
    cyc(); put(1, 5, 1, 0, 0, 5, 1, 1, 0, 1, 7); expect1("rst0", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 7, 1, 2, 0, 1, 7); expect1("rst1", 0, 1, 32'h0, 0);
    cyc(); rst_n = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);        expect1("rst_rel", 0, 0, 32'h0, 0);

    // Load-use through rs, then through rt, then unused sources.
    cyc(); put(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0); expect1("ld5", 0, 1, 32'h0, 0);
    cyc(); put(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0); expect1("use5_stall", 1, 0, 32'h20, 0);
    cyc(); put(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0); expect1("use5_issue", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); expect1("ld3", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 3, 1, 4, 1, 0, 0, 0, 0); expect1("rt3_stall", 1, 0, 32'h8, 0);
    cyc(); put(1, 0, 0, 3, 1, 4, 1, 0, 0, 0, 0); expect1("rt3_issue", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0); expect1("ld3b", 0, 1, 32'h0, 0);
    cyc(); put(1, 3, 0, 3, 0, 3, 0, 0, 0, 0, 0); expect1("unused3", 0, 1, 32'h8, 0);

    // Long op on r7 with a RAW dependent, then a WAW dependent.
    cyc(); put(1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0); expect1("lg7", 0, 1, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); put(1, 0, 0, 7, 1, 2, 1, 0, 0, 0, 0); expect1("raw7_wait", 1, 0, 32'h80, 0);
    end
    cyc(); put(1, 0, 0, 7, 1, 2, 1, 0, 0, 1, 7); expect1("raw7_wb", 1, 0, 32'h80, 0);
    cyc(); put(1, 0, 0, 7, 1, 2, 1, 0, 0, 0, 0); expect1("raw7_issue", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0); expect1("lg7b", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); expect1("waw7_wait", 1, 0, 32'h80, 0);
    cyc(); put(1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7); expect1("waw7_wb", 1, 0, 32'h80, 0);
    cyc(); put(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0); expect1("waw7_issue", 0, 1, 32'h0, 0);

    // Structural limit, and a long issue coinciding with a completion.
    cyc(); put(1, 0, 0, 0, 0, 8, 1, 2, 0, 0, 0);  expect1("lg8", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 9, 1, 2, 0, 0, 0);  expect1("lg9", 0, 1, 32'h100, 0);
    cyc(); put(1, 0, 0, 0, 0, 10, 1, 2, 0, 0, 0); expect1("lg10_full", 1, 0, 32'h300, 1);
    cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);  expect1("wb8", 0, 0, 32'h300, 1);
    cyc(); put(1, 0, 0, 0, 0, 10, 1, 2, 0, 1, 9); expect1("lg10_wb9", 0, 1, 32'h200, 0);
    cyc(); put(1, 0, 0, 0, 0, 11, 1, 2, 0, 0, 0); expect1("lg11", 0, 1, 32'h400, 0);
    cyc(); put(1, 0, 0, 0, 0, 12, 1, 2, 0, 0, 0); expect1("lg12_full", 1, 0, 32'hC00, 1);
    cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12); expect1("wb_stray", 0, 0, 32'hC00, 1);
    cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  expect1("stray_ign", 0, 0, 32'hC00, 1);
    cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10); expect1("wb10", 0, 0, 32'hC00, 1);
    cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11); expect1("wb11", 0, 0, 32'h800, 0);

    // Untracked long ops (rd=0, rd_wr=0) do not consume long_cnt.
    cyc(); put(1, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);  expect1("lg_r0", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 13, 0, 2, 0, 0, 0); expect1("lg_nowr", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 14, 1, 2, 0, 0, 0); expect1("lg14", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 15, 1, 2, 0, 0, 0); expect1("lg15", 0, 1, 32'h4000, 0);
    cyc(); put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  expect1("full2", 0, 0, 32'hC000, 1);

    // Flush: hazards masked, and the squashed load/long sets nothing.
    cyc(); put(1, 14, 1, 0, 0, 20, 1, 1, 1, 0, 0); expect1("flush_raw", 0, 0, 32'hC000, 1);
    cyc(); put(1, 20, 1, 0, 0, 21, 0, 0, 0, 0, 0); expect1("after_flush", 0, 1, 32'hC000, 1);
    cyc(); put(1, 0, 0, 0, 0, 16, 1, 2, 1, 0, 0);  expect1("flush_struct", 0, 0, 32'hC000, 1);

    // r0 is never busy.
    cyc(); put(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); expect1("ld_r0", 0, 1, 32'hC000, 1);
    cyc(); put(1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0); expect1("read_r0", 0, 1, 32'hC000, 1);

    // Reset mid-operation, then a stale completion.
    cyc(); put(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);  expect1("ld5_pend", 0, 1, 32'hC000, 1);
    cyc(); rst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);         expect1("mid_rst", 0, 0, 32'hC020, 1);
    cyc(); rst_n = 1'b1;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14);        expect1("stale_wb", 0, 0, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 17, 1, 2, 0, 0, 0); expect1("lg17", 0, 1, 32'h0, 0);
    cyc(); put(1, 0, 0, 0, 0, 18, 1, 2, 0, 0, 0); expect1("lg18", 0, 1, 32'h20000, 0);
    cyc(); put(1, 0, 0, 0, 0, 19, 1, 2, 0, 0, 0); expect1("lg19_full", 1, 0, 32'h60000, 1);

    // LOAD_LAT=3 on dut3: a dependent stalls for three cycles.
    cyc(); rst_n = 1'b0;
    put(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);         expect1("rst3", 0, 0, 32'h60000, 1);
    cyc(); rst_n = 1'b1;
    put(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    expect3("l3_ld5", 0, 1, 32'h0, 0, 0, 1, 32'h0);
    cyc(); put(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    expect3("l3_use1", 1, 0, 32'h20, 0, 1, 0, 32'h20);
    cyc(); put(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    expect3("l3_use2", 0, 1, 32'h0, 0, 1, 0, 32'h20);
    cyc(); put(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    expect3("l3_use3", 0, 1, 32'h0, 0, 1, 0, 32'h20);
    cyc(); put(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    expect3("l3_issue", 0, 1, 32'h0, 0, 0, 1, 32'h0);

    // Drain: give the monitor a bounded number of cycles.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got=%0d entries left expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
